// File: rtl/mem_stage_if.sv
// Data-memory port of the memory stage: single-outstanding request/ready bus.
// master = memory stage (issues requests), slave = data memory.
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_wdata,
      output dmem_wstrb,
      input  dmem_ready,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_wdata,
      input  dmem_wstrb,
      output dmem_ready,
      output dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// RV64 pipeline memory stage. Non-memory instructions pass to WB in one
// cycle; loads/stores go through a two-state FSM (IDLE, REQ) that holds the
// request stable on the data-memory port until dmem_ready, stalling EX.
// Optional feature macro MEM_MISALIGN_TRAP_EN: when defined, misaligned
// accesses are suppressed and flagged on wb_misalign; when undefined, the
// low address bits are forced to natural alignment and the access proceeds.
module mem_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_mem_read,
   input  logic        ex_mem_write,
   input  logic [2:0]  ex_funct3,
   input  logic [63:0] ex_alu_result,
   input  logic [63:0] ex_rs2_data,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_write,
   output logic        mem_stall,
   mem_stage_if.master dmem,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic        wb_reg_write,
   output logic [63:0] wb_data,
   output logic        wb_misalign
);

   localparam int DATA_W = 64;

   typedef enum logic {IDLE, REQ} state_t;

   state_t state_q, state_d;

   // Request captured at the accept edge and held through REQ
   logic              we_p1;
   logic [DATA_W-1:0] addr_p1;
   logic [DATA_W-1:0] wdata_p1;
   logic [7:0]        wstrb_p1;
   logic [1:0]        size_p1;
   logic              unsigned_p1;
   logic [4:0]        rd_p1;
   logic              reg_write_p1;

   // EX-side decode
   logic              mem_op;
   logic              illegal;
   logic              trap;
   logic              accept_mem;
   logic [1:0]        size;
   logic [2:0]        lane;
   logic [DATA_W-1:0] acc_addr;
   logic [DATA_W-1:0] st_wdata;
   logic [7:0]        st_wstrb;
`ifdef MEM_MISALIGN_TRAP_EN
   logic              misal;
`endif

   // Low address bits that must be zero for a naturally aligned access
   function automatic logic [2:0] align_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   align_mask = 3'b000;
         2'b01:   align_mask = 3'b001;
         2'b10:   align_mask = 3'b011;
         default: align_mask = 3'b111;
      endcase
   endfunction

   // Byte-enable pattern for an access of the given size at lane 0
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   // Shift the addressed bytes down, truncate to size, then sign/zero extend
   function automatic logic [DATA_W-1:0] load_extract(
      input logic [DATA_W-1:0] rdata,
      input logic [2:0]        ln,
      input logic [1:0]        sz,
      input logic              uns
   );
      logic [DATA_W-1:0]        sh;
      logic signed [7:0]        b8;
      logic signed [15:0]       h16;
      logic signed [31:0]       w32;
      logic signed [DATA_W-1:0] sx;
      sh  = rdata >> {ln, 3'b000};
      b8  = sh[7:0];
      h16 = sh[15:0];
      w32 = sh[31:0];
      case (sz)
         2'b00: begin
            sx = DATA_W'(b8);
            load_extract = uns ? {56'd0, sh[7:0]} : $unsigned(sx);
         end
         2'b01: begin
            sx = DATA_W'(h16);
            load_extract = uns ? {48'd0, sh[15:0]} : $unsigned(sx);
         end
         2'b10: begin
            sx = DATA_W'(w32);
            load_extract = uns ? {32'd0, sh[31:0]} : $unsigned(sx);
         end
         default: load_extract = sh;
      endcase
   endfunction

   // State register; asynchronous reset abandons any request in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // EX decode (legality, alignment, lane placement) and next-state logic
   always_comb begin
      state_d  = state_q;
      mem_op   = ex_mem_read | ex_mem_write;
      size     = ex_funct3[1:0];
      illegal  = (ex_mem_read & ex_mem_write)
               | (ex_mem_read & (ex_funct3 == 3'b111))
               | (ex_mem_write & ex_funct3[2]);
      acc_addr = {ex_alu_result[DATA_W-1:3], ex_alu_result[2:0] & ~align_mask(size)};
`ifdef MEM_MISALIGN_TRAP_EN
      misal    = |(ex_alu_result[2:0] & align_mask(size));
      trap     = illegal | misal;
`else
      trap     = illegal;
`endif
      lane       = acc_addr[2:0];
      st_wdata   = ex_rs2_data << {lane, 3'b000};
      st_wstrb   = size_mask(size) << lane;
      accept_mem = (state_q == IDLE) & ex_valid & mem_op & ~trap;
      case (state_q)
         IDLE:    if (accept_mem) state_d = REQ;
         REQ:     if (dmem.dmem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture the memory request at accept so the bus stays stable in REQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_p1        <= 1'b0;
         addr_p1      <= '0;
         wdata_p1     <= '0;
         wstrb_p1     <= '0;
         size_p1      <= '0;
         unsigned_p1  <= 1'b0;
         rd_p1        <= '0;
         reg_write_p1 <= 1'b0;
      end else if (accept_mem) begin
         we_p1        <= ex_mem_write;
         addr_p1      <= {acc_addr[DATA_W-1:3], 3'b000};
         wdata_p1     <= st_wdata;
         wstrb_p1     <= st_wstrb;
         size_p1      <= size;
         unsigned_p1  <= ex_funct3[2];
         rd_p1        <= ex_rd;
         reg_write_p1 <= ex_reg_write;
      end
   end

   // Writeback bundle: passthrough, suppressed-access report, or memory result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid     <= 1'b0;
         wb_rd        <= '0;
         wb_reg_write <= 1'b0;
         wb_data      <= '0;
         wb_misalign  <= 1'b0;
      end else begin
         wb_valid    <= 1'b0;
         wb_misalign <= 1'b0;
         if (state_q == IDLE) begin
            if (ex_valid && !mem_op) begin
               wb_valid     <= 1'b1;
               wb_rd        <= ex_rd;
               wb_reg_write <= ex_reg_write;
               wb_data      <= ex_alu_result;
            end else if (ex_valid && trap) begin
               wb_valid     <= 1'b1;
               wb_rd        <= ex_rd;
               wb_reg_write <= 1'b0;
               wb_misalign  <= 1'b1;
            end
         end else if (dmem.dmem_ready) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_p1;
            if (we_p1) begin
               wb_reg_write <= 1'b0;
            end else begin
               wb_reg_write <= reg_write_p1;
               wb_data      <= load_extract(dmem.dmem_rdata, addr_p1[2:0] | lane_of(size_p1, wstrb_p1), size_p1, unsigned_p1);
            end
         end
      end
   end

   // Byte lane recovered from the captured strobe (lowest enabled byte)
   function automatic logic [2:0] lane_of(input logic [1:0] sz, input logic [7:0] strb);
      logic [2:0] ln;
      ln = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (strb[i]) ln = 3'(i);
      end
      lane_of = ln & ~align_mask(sz);
   endfunction

   assign mem_stall       = (state_q == REQ);
   assign dmem.dmem_req   = (state_q == REQ);
   assign dmem.dmem_we    = we_p1 & (state_q == REQ);
   assign dmem.dmem_addr  = addr_p1;
   assign dmem.dmem_wdata = wdata_p1;
   assign dmem.dmem_wstrb = wstrb_p1;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected WB bundles into a
// queue; an independent monitor pops and compares whenever wb_valid is high.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic [2:0]  ex_funct3;
   logic [63:0] ex_alu_result;
   logic [63:0] ex_rs2_data;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;
   logic        mem_stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        wb_reg_write;
   logic [63:0] wb_data;
   logic        wb_misalign;

   mem_stage_if dmem ();

   mem_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_mem_read   (ex_mem_read),
      .ex_mem_write  (ex_mem_write),
      .ex_funct3     (ex_funct3),
      .ex_alu_result (ex_alu_result),
      .ex_rs2_data   (ex_rs2_data),
      .ex_rd         (ex_rd),
      .ex_reg_write  (ex_reg_write),
      .mem_stall     (mem_stall),
      .dmem          (dmem),
      .wb_valid      (wb_valid),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_data       (wb_data),
      .wb_misalign   (wb_misalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [4:0]  rd;
      logic        rw;
      logic [63:0] data;
      logic        mis;
      logic        chkd;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_wb(input int id, input logic [4:0] rd, input logic rw,
                            input logic [63:0] d, input logic mis, input logic chkd);
      exp_t e;
      e.id = id; e.rd = rd; e.rw = rw; e.data = d; e.mis = mis; e.chkd = chkd;
      q.push_back(e);
   endtask

   // Present one EX bundle for exactly one accept edge
   task automatic drive_ex(input logic rd_, input logic wr_, input logic [2:0] f3,
                           input logic [63:0] a, input logic [63:0] d,
                           input logic [4:0] rd, input logic rw);
      ex_mem_read   = rd_;
      ex_mem_write  = wr_;
      ex_funct3     = f3;
      ex_alu_result = a;
      ex_rs2_data   = d;
      ex_rd         = rd;
      ex_reg_write  = rw;
      ex_valid      = 1'b1;
      @(posedge clk); #1;
      ex_valid     = 1'b0;
      ex_mem_read  = 1'b0;
      ex_mem_write = 1'b0;
   endtask

   // Memory model: assert ready on the dly-th REQ cycle; count stalled cycles
   task automatic respond(input int dly, input logic [63:0] rdata, output int st);
      st = 0;
      for (int i = 1; i < dly; i++) begin
         @(negedge clk);
         if (mem_stall) st++;
         @(posedge clk); #1;
      end
      dmem.dmem_ready = 1'b1;
      dmem.dmem_rdata = rdata;
      @(negedge clk);
      if (mem_stall) st++;
      @(posedge clk); #1;
      dmem.dmem_ready = 1'b0;
      dmem.dmem_rdata = '0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && wb_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d expected no writeback", wb_rd);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk($sformatf("wb%0d_rd", e.id), 64'(wb_rd), 64'(e.rd));
            chk($sformatf("wb%0d_reg_write", e.id), 64'(wb_reg_write), 64'(e.rw));
            chk($sformatf("wb%0d_misalign", e.id), 64'(wb_misalign), 64'(e.mis));
            if (e.chkd) chk($sformatf("wb%0d_data", e.id), wb_data, e.data);
         end
      end
   end

   initial begin
      int st;
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
      ex_alu_result = '0; ex_rs2_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
      dmem.dmem_ready = 1'b0; dmem.dmem_rdata = '0;
      #22;
      chk("rst_req",       64'(dmem.dmem_req), 64'd0);
      chk("rst_we",        64'(dmem.dmem_we), 64'd0);
      chk("rst_addr",      dmem.dmem_addr, 64'd0);
      chk("rst_wdata",     dmem.dmem_wdata, 64'd0);
      chk("rst_wstrb",     64'(dmem.dmem_wstrb), 64'd0);
      chk("rst_wb_valid",  64'(wb_valid), 64'd0);
      chk("rst_wb_data",   wb_data, 64'd0);
      chk("rst_wb_rd",     64'(wb_rd), 64'd0);
      chk("rst_wb_rw",     64'(wb_reg_write), 64'd0);
      chk("rst_wb_mis",    64'(wb_misalign), 64'd0);
      chk("rst_stall",     64'(mem_stall), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // ADD passthrough
      expect_wb(1, 5'd5, 1'b1, 64'h1234, 1'b0, 1'b1);
      drive_ex(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 5'd5, 1'b1);
      chk("add_lat",   64'(wb_valid), 64'd1);
      chk("add_stall", 64'(mem_stall), 64'd0);
      chk("add_req",   64'(dmem.dmem_req), 64'd0);

      // LB sign-extend, lane 3, ready on first REQ cycle
      expect_wb(2, 5'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
      drive_ex(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 5'd6, 1'b1);
      chk("lb_req",   64'(dmem.dmem_req), 64'd1);
      chk("lb_we",    64'(dmem.dmem_we), 64'd0);
      chk("lb_addr",  dmem.dmem_addr, 64'h1000);
      chk("lb_stall", 64'(mem_stall), 64'd1);
      respond(1, 64'h0000_0000_8000_0000, st);
      chk("lb_lat",   64'(wb_valid), 64'd1);
      chk("lb_idle",  64'(mem_stall), 64'd0);

      // LWU with 3-cycle ready delay; an ADD held on EX during REQ follows
      expect_wb(3, 5'd7, 1'b1, 64'h0000_0000_89AB_CDEF, 1'b0, 1'b1);
      expect_wb(4, 5'd8, 1'b1, 64'h77, 1'b0, 1'b1);
      drive_ex(1'b1, 1'b0, 3'b110, 64'h2004, 64'h0, 5'd7, 1'b1);
      chk("lwu_addr", dmem.dmem_addr, 64'h2000);
      ex_funct3 = 3'b000; ex_alu_result = 64'h77; ex_rd = 5'd8; ex_reg_write = 1'b1;
      ex_valid = 1'b1;
      respond(3, 64'h89AB_CDEF_0123_4567, st);
      chk("lwu_stall_cycles", 64'(st), 64'd3);
      chk("lwu_lat", 64'(wb_valid), 64'd1);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      chk("b2b_lat", 64'(wb_valid), 64'd1);

      // SH at lane 6
      expect_wb(5, 5'd9, 1'b0, 64'h0, 1'b0, 1'b0);
      drive_ex(1'b0, 1'b1, 3'b001, 64'h3006, 64'hBEEF, 5'd9, 1'b1);
      chk("sh_we",    64'(dmem.dmem_we), 64'd1);
      chk("sh_addr",  dmem.dmem_addr, 64'h3000);
      chk("sh_wstrb", 64'(dmem.dmem_wstrb), 64'hC0);
      chk("sh_wdata", dmem.dmem_wdata, 64'hBEEF_0000_0000_0000);
      @(posedge clk); #1;
      chk("sh_hold_wstrb", 64'(dmem.dmem_wstrb), 64'hC0);
      chk("sh_hold_req",   64'(dmem.dmem_req), 64'd1);
      respond(1, 64'h0, st);
      chk("sh_lat", 64'(wb_valid), 64'd1);

      // Misaligned LW at 0x4002
`ifdef MEM_MISALIGN_TRAP_EN
      expect_wb(6, 5'd10, 1'b0, 64'h0, 1'b1, 1'b0);
      drive_ex(1'b1, 1'b0, 3'b010, 64'h4002, 64'h0, 5'd10, 1'b1);
      chk("mis_req",   64'(dmem.dmem_req), 64'd0);
      chk("mis_stall", 64'(mem_stall), 64'd0);
      chk("mis_flag",  64'(wb_misalign), 64'd1);
`else
      expect_wb(6, 5'd10, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1);
      drive_ex(1'b1, 1'b0, 3'b010, 64'h4002, 64'h0, 5'd10, 1'b1);
      chk("mis_req",  64'(dmem.dmem_req), 64'd1);
      chk("mis_addr", dmem.dmem_addr, 64'h4000);
      respond(1, 64'hAAAA_AAAA_8000_0001, st);
      chk("mis_flag", 64'(wb_misalign), 64'd0);
`endif

      // Illegal encodings: LDU-like load, store with funct3[2], read+write
      expect_wb(7, 5'd11, 1'b0, 64'h0, 1'b1, 1'b0);
      drive_ex(1'b1, 1'b0, 3'b111, 64'h5000, 64'h0, 5'd11, 1'b1);
      chk("ill_ld_req",   64'(dmem.dmem_req), 64'd0);
      chk("ill_ld_stall", 64'(mem_stall), 64'd0);
      expect_wb(8, 5'd12, 1'b0, 64'h0, 1'b1, 1'b0);
      drive_ex(1'b0, 1'b1, 3'b100, 64'h5000, 64'h0, 5'd12, 1'b1);
      chk("ill_st_req", 64'(dmem.dmem_req), 64'd0);
      expect_wb(9, 5'd13, 1'b0, 64'h0, 1'b1, 1'b0);
      drive_ex(1'b1, 1'b1, 3'b011, 64'h5000, 64'h0, 5'd13, 1'b1);
      chk("ill_rw_req", 64'(dmem.dmem_req), 64'd0);

      // LD aligned
      expect_wb(10, 5'd14, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1);
      drive_ex(1'b1, 1'b0, 3'b011, 64'h5000, 64'h0, 5'd14, 1'b1);
      respond(2, 64'hDEAD_BEEF_CAFE_F00D, st);

      // LHU lane 2 and LH lane 6 (sign)
      expect_wb(11, 5'd15, 1'b1, 64'h0000_0000_0000_ABCD, 1'b0, 1'b1);
      drive_ex(1'b1, 1'b0, 3'b101, 64'h6002, 64'h0, 5'd15, 1'b1);
      respond(1, 64'h0000_0000_ABCD_0000, st);
      expect_wb(12, 5'd16, 1'b1, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b1);
      drive_ex(1'b1, 1'b0, 3'b001, 64'h600E, 64'h0, 5'd16, 1'b1);
      respond(1, 64'h8001_0000_0000_0000, st);

      // SB lane 5 and SD
      expect_wb(13, 5'd17, 1'b0, 64'h0, 1'b0, 1'b0);
      drive_ex(1'b0, 1'b1, 3'b000, 64'h7005, 64'h1234_56A5, 5'd17, 1'b1);
      chk("sb_wstrb", 64'(dmem.dmem_wstrb), 64'h20);
      chk("sb_wdata", dmem.dmem_wdata, 64'h3456_A500_0000_0000);
      chk("sb_addr",  dmem.dmem_addr, 64'h7000);
      respond(1, 64'h0, st);
      expect_wb(14, 5'd18, 1'b0, 64'h0, 1'b0, 1'b0);
      drive_ex(1'b0, 1'b1, 3'b011, 64'h8000, 64'h0123_4567_89AB_CDEF, 5'd18, 1'b1);
      chk("sd_wstrb", 64'(dmem.dmem_wstrb), 64'hFF);
      chk("sd_wdata", dmem.dmem_wdata, 64'h0123_4567_89AB_CDEF);
      respond(1, 64'h0, st);

      // Reset during REQ: request dropped asynchronously, no writeback
      drive_ex(1'b1, 1'b0, 3'b011, 64'h9000, 64'h0, 5'd19, 1'b1);
      chk("rq_req_before", 64'(dmem.dmem_req), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rq_req_async", 64'(dmem.dmem_req), 64'd0);
      chk("rq_stall",     64'(mem_stall), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      expect_wb(15, 5'd3, 1'b1, 64'hCAFE, 1'b0, 1'b1);
      drive_ex(1'b0, 1'b0, 3'b000, 64'hCAFE, 64'h0, 5'd3, 1'b1);
      chk("rq_add_lat", 64'(wb_valid), 64'd1);

      repeat (3) @(negedge clk);
      #1;
      chk("sb_pending", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
